// File: rtl/vga_timing_pkg.sv
// Shared video timing constants for the display pipeline.
// Downstream stages import this package so their edge tests stay aligned
// with the generator.
package vga_timing_pkg;

  // Width of every horizontal/vertical counter in the pipeline.
  localparam int COUNT_W = 11;

  // One bit wider than a count, so sync-window arithmetic cannot overflow.
  typedef logic [COUNT_W:0] wide_count_t;

  // XGA 1024x768 @ 60 Hz, 65 MHz pixel clock.
  localparam int XGA_H_ACTIVE     = 1024;
  localparam int XGA_H_SYNC_START = 1048;
  localparam int XGA_H_SYNC_LEN   = 136;
  localparam int XGA_H_TOTAL      = 1344;
  localparam int XGA_V_ACTIVE     = 768;
  localparam int XGA_V_SYNC_START = 771;
  localparam int XGA_V_SYNC_LEN   = 6;
  localparam int XGA_V_TOTAL      = 806;

  // SVGA 800x600 @ 60 Hz, 40 MHz pixel clock (alternate mode).
  localparam int SVGA_H_ACTIVE     = 800;
  localparam int SVGA_H_SYNC_START = 840;
  localparam int SVGA_H_SYNC_LEN   = 128;
  localparam int SVGA_H_TOTAL      = 1056;
  localparam int SVGA_V_ACTIVE     = 600;
  localparam int SVGA_V_SYNC_START = 601;
  localparam int SVGA_V_SYNC_LEN   = 4;
  localparam int SVGA_V_TOTAL      = 628;

  // True when value lies in [start, start+len-1]. The subtraction is done one
  // bit wider, so a value below start wraps to a large offset (>= len).
  function automatic logic in_window(input logic [COUNT_W-1:0] value,
                                     input int start, input int len);
    wide_count_t offset;
    offset = {1'b0, value} - wide_count_t'(start);
    return offset < wide_count_t'(len);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping counter plus its registered sync and blanking
// flags. The flags are computed from the next count, so they always describe
// the count presented in the same cycle.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE     = XGA_H_ACTIVE,
  parameter int SYNC_START = XGA_H_SYNC_START,
  parameter int SYNC_LEN   = XGA_H_SYNC_LEN,
  parameter int TOTAL      = XGA_H_TOTAL
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               step,
  output logic [COUNT_W-1:0] count,
  output logic               sync,
  output logic               blnk,
  output logic               wrap
);

  localparam logic [COUNT_W-1:0] LAST     = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] ACTIVE_C = COUNT_W'(ACTIVE);

  logic [COUNT_W-1:0] count_next;

  // Wrap is asserted on the step that takes the counter from its last value to 0.
  always_comb begin
    wrap = step && (count == LAST);
  end

  // Next count: hold, increment, or wrap to zero.
  always_comb begin
    count_next = count;
    if (wrap) begin
      count_next = '0;
    end else if (step) begin
      count_next = count + COUNT_W'(1);
    end
  end

  // Register the count and the flags derived from the same next value.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sync  <= 1'b0;
      blnk  <= 1'b0;
    end else begin
      count <= count_next;
      sync  <= in_window(count_next, SYNC_START, SYNC_LEN);
      blnk  <= (count_next >= ACTIVE_C);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running video timing source: counters, active-high syncs, blanking
// and a one-cycle frame-start tick, all registered on pclk. The stream is
// continuous; there is no enable or handshake.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE     = XGA_H_ACTIVE,
  parameter int H_SYNC_START = XGA_H_SYNC_START,
  parameter int H_SYNC_LEN   = XGA_H_SYNC_LEN,
  parameter int H_TOTAL      = XGA_H_TOTAL,
  parameter int V_ACTIVE     = XGA_V_ACTIVE,
  parameter int V_SYNC_START = XGA_V_SYNC_START,
  parameter int V_SYNC_LEN   = XGA_V_SYNC_LEN,
  parameter int V_TOTAL      = XGA_V_TOTAL
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        frame_start_out
);

  logic h_wrap;
  logic v_wrap;

  // Horizontal axis steps every pixel clock.
  vga_axis_counter #(
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_SYNC_START),
    .SYNC_LEN   (H_SYNC_LEN),
    .TOTAL      (H_TOTAL)
  ) u_h_axis (
    .pclk  (pclk),
    .rst   (rst),
    .step  (1'b1),
    .count (hcount_out),
    .sync  (hsync_out),
    .blnk  (hblnk_out),
    .wrap  (h_wrap)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_SYNC_START),
    .SYNC_LEN   (V_SYNC_LEN),
    .TOTAL      (V_TOTAL)
  ) u_v_axis (
    .pclk  (pclk),
    .rst   (rst),
    .step  (h_wrap),
    .count (vcount_out),
    .sync  (vsync_out),
    .blnk  (vblnk_out),
    .wrap  (v_wrap)
  );

  // Frame tick lands on the cycle the counters present (0,0) after a full
  // frame; the reset state never produces it.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_start_out <= 1'b0;
    end else begin
      frame_start_out <= h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one instance with the default XGA timing and one
// reduced-size instance so that full frames fit in a short run. A model steps
// a frame position per clock and pushes expected output vectors; a monitor on
// the falling edge pops and compares them.
module tb_vga_timing_gen;

  // Reduced mode for the small instance (same shape as XGA, smaller numbers).
  localparam int SHA  = 64;
  localparam int SHSS = 70;
  localparam int SHSL = 9;
  localparam int SHT  = 84;
  localparam int SVA  = 48;
  localparam int SVSS = 51;
  localparam int SVSL = 3;
  localparam int SVT  = 56;
  localparam int SF   = SHT * SVT;
  localparam int DF   = 1344 * 806;

  logic pclk;
  logic rst;

  logic [10:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic d_hsync, d_vsync, d_hblnk, d_vblnk, d_fs;
  logic s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs;

  int checks   = 0;
  int failures = 0;

  logic [26:0] exp_d[$];
  logic [26:0] exp_s[$];

  vga_timing_gen u_dut_xga (
    .pclk            (pclk),
    .rst             (rst),
    .hcount_out      (d_hcount),
    .vcount_out      (d_vcount),
    .hsync_out       (d_hsync),
    .vsync_out       (d_vsync),
    .hblnk_out       (d_hblnk),
    .vblnk_out       (d_vblnk),
    .frame_start_out (d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE     (SHA),
    .H_SYNC_START (SHSS),
    .H_SYNC_LEN   (SHSL),
    .H_TOTAL      (SHT),
    .V_ACTIVE     (SVA),
    .V_SYNC_START (SVSS),
    .V_SYNC_LEN   (SVSL),
    .V_TOTAL      (SVT)
  ) u_dut_small (
    .pclk            (pclk),
    .rst             (rst),
    .hcount_out      (s_hcount),
    .vcount_out      (s_vcount),
    .hsync_out       (s_hsync),
    .vsync_out       (s_vsync),
    .hblnk_out       (s_hblnk),
    .vblnk_out       (s_vblnk),
    .frame_start_out (s_fs)
  );

  // Clock
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Reference: output vector for a position within the frame, derived from
  // the timing rules with plain arithmetic.
  function automatic logic [26:0] ref_vec(input int pos, input bit fs,
                                          input int ha, input int hss, input int hsl, input int ht,
                                          input int va, input int vss, input int vsl);
    int h;
    int v;
    logic [10:0] hh;
    logic [10:0] vv;
    h  = pos % ht;
    v  = pos / ht;
    hh = 11'(h);
    vv = 11'(v);
    return {hh, vv, (h >= hss && h < hss + hsl), (v >= vss && v < vss + vsl),
            (h >= ha), (v >= va), fs};
  endfunction

  // Model: one expected vector per rising edge for each instance.
  initial begin
    int pos_d;
    int pos_s;
    pos_d = 0;
    pos_s = 0;
    forever begin
      @(posedge pclk);
      if (rst) begin
        pos_d = 0;
        pos_s = 0;
        exp_d.push_back('0);
        exp_s.push_back('0);
      end else begin
        pos_d = (pos_d + 1) % DF;
        pos_s = (pos_s + 1) % SF;
        exp_d.push_back(ref_vec(pos_d, pos_d == 0, 1024, 1048, 136, 1344, 768, 771, 6));
        exp_s.push_back(ref_vec(pos_s, pos_s == 0, SHA, SHSS, SHSL, SHT, SVA, SVSS, SVSL));
      end
    end
  end

  // Monitor: pop and compare every cycle, plus hsync width and pulse spacing.
  initial begin
    logic [26:0] e;
    logic [26:0] a;
    int cyc;
    int last_fs;
    int hs_run;
    cyc     = 0;
    last_fs = -1;
    hs_run  = 0;
    forever begin
      @(negedge pclk);
      cyc++;
      a = {d_hcount, d_vcount, d_hsync, d_vsync, d_hblnk, d_vblnk, d_fs};
      checks++;
      if (exp_d.size() == 0) begin
        failures++;
        $display("FAIL stream_xga: no expected entry, actual %h", a);
      end else begin
        e = exp_d.pop_front();
        if (rst) e = '0;
        if (a !== e) begin
          failures++;
          $display("FAIL stream_xga t=%0t: actual %h expected %h", $time, a, e);
        end
      end
      a = {s_hcount, s_vcount, s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs};
      checks++;
      if (exp_s.size() == 0) begin
        failures++;
        $display("FAIL stream_small: no expected entry, actual %h", a);
      end else begin
        e = exp_s.pop_front();
        if (rst) e = '0;
        if (a !== e) begin
          failures++;
          $display("FAIL stream_small t=%0t: actual %h expected %h", $time, a, e);
        end
      end
      if (rst) begin
        last_fs = -1;
        hs_run  = 0;
      end else begin
        if (d_hsync) begin
          hs_run++;
        end else if (hs_run > 0) begin
          checks++;
          if (hs_run != 136) begin
            failures++;
            $display("FAIL hsync_width: actual %0d expected 136", hs_run);
          end
          hs_run = 0;
        end
        if (s_fs) begin
          if (last_fs >= 0) begin
            checks++;
            if (cyc - last_fs != SF) begin
              failures++;
              $display("FAIL frame_spacing: actual %0d expected %0d", cyc - last_fs, SF);
            end
          end
          last_fs = cyc;
        end
      end
    end
  end

  // Stimulus: reset, free run, asynchronous mid-frame reset, restart timing.
  initial begin
    bit found;
    int first_k;
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    #2 rst = 1'b0;

    // Two full small frames plus margin; covers several XGA lines.
    repeat (2 * SF + 20 + $urandom_range(0, 200)) @(posedge pclk);

    // Locate a mid-frame position in the small instance.
    found = 1'b0;
    for (int i = 0; i < SF + 2 && !found; i++) begin
      @(negedge pclk);
      if (s_hcount == 11'd30 && s_vcount == 11'd20) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL find_midframe: position (30,20) not reached within %0d cycles", SF + 2);
    end

    // Assert reset between edges; outputs must clear without a clock.
    @(posedge pclk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({d_hcount, d_vcount, d_hsync, d_vsync, d_hblnk, d_vblnk, d_fs} !== 27'd0) begin
      failures++;
      $display("FAIL async_reset_xga: actual %h expected 0",
               {d_hcount, d_vcount, d_hsync, d_vsync, d_hblnk, d_vblnk, d_fs});
    end
    checks++;
    if ({s_hcount, s_vcount, s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs} !== 27'd0) begin
      failures++;
      $display("FAIL async_reset_small: actual %h expected 0",
               {s_hcount, s_vcount, s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs});
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    #2 rst = 1'b0;

    // The first pulse after restart arrives exactly one frame later.
    first_k = -1;
    for (int k = 1; k <= SF + 10; k++) begin
      @(posedge pclk);
      #1;
      if (s_fs && first_k < 0) first_k = k;
    end
    checks++;
    if (first_k != SF) begin
      failures++;
      $display("FAIL restart_pulse: actual %0d cycles expected %0d", first_k, SF);
    end

    repeat (5) @(posedge pclk);
    @(negedge pclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
